grn_attractor_ctrl: RTL
=======================

Name: grn_attractor_ctrl

Overview:
- Sequencer for an array of NODES two-copy GRN nodes.
- Each node holds a half-rate copy s0 (internal pass toggle: first start_s0 after reset_nos updates, the next skips) and a full-rate copy s1.
- For every initial state 0..2^NODES-1 the block loads the array, runs tortoise/hare stepping until the two copies meet, measures the attractor period, and reports one result per initial state over a valid/ready interface.

Parameters:
- NODES, 4, number of nodes; width of state vectors and of the initial-state counter.
- STEP_W, 16, width of the step and period counters.
- MAX_STEPS, 1000, step limit for each of RUN and PERIOD; reaching it sets a timeout. Must be ≤ 2^STEP_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- start  in  1  one-cycle pulse: begin sweep; ignored unless IDLE
- busy  out  1  high from the cycle after an accepted start until DONE returns to IDLE
- done  out  1  one-cycle pulse after the last result is accepted
- reset_nos  out  1  to all nodes: load init_state
- start_s0  out  1  to all nodes: advance s0 copy (pass-gated inside node)
- start_s1  out  1  to all nodes: advance s1 copy
- init_state  out  NODES  bit i drives node i init_state
- s0_vec  in  NODES  concatenated node s0 outputs
- s1_vec  in  NODES  concatenated node s1 outputs
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts when res_valid&&res_ready
- res_init  out  NODES  initial state of this result
- res_meet  out  STEP_W  step count k at meet (or MAX_STEPS on timeout)
- res_period  out  STEP_W  attractor period (0 on timeout)
- res_timeout  out  1  RUN or PERIOD hit MAX_STEPS

Behaviour:
- All registered outputs reset to 0: busy, done, reset_nos, res_*, init_state, counters. FSM → IDLE.
- start_s0 and start_s1 are combinational from state, counters and the vector compare; they are 0 in reset and IDLE.
- rst in any state (mid-RUN included) aborts the sweep with no result; node state is don't-care until the next LOAD.
- FSM states: IDLE, LOAD, RUN, PERIOD, REPORT, DONE.
- IDLE:
  - start → LOAD; cur_init=0.
- LOAD (1 cycle):
  - reset_nos=1, init_state=cur_init; step=0, per=0.
  - → RUN.
- RUN:
  - match = (step≥2) && (s0_vec==s1_vec). After k steps, s0=f^ceil(k/2)(x0) and s1=f^k(x0); step<2 is never compared.
  - If match: starts=0, meet=step → PERIOD.
  - Else if step==MAX_STEPS: starts=0, meet=MAX_STEPS, timeout=1 → REPORT.
  - Else: start_s0=start_s1=1, step++.
  - Compare uses vectors present in the current cycle; node registers update at the same edge.
- PERIOD:
  - start_s0=0 (tortoise frozen).
  - If per≥1 && s1_vec==s0_vec: period=per → REPORT.
  - Else if per==MAX_STEPS: timeout=1, period=0 → REPORT.
  - Else: start_s1=1, per++.
- REPORT:
  - res_valid=1; all res_* held stable until the handshake.
  - On accept: if cur_init==2^NODES-1 → DONE; else cur_init++ → LOAD.
  - res_valid deasserts the cycle after accept.
- DONE:
  - done=1 for one cycle, busy=0 → IDLE.
- Counters saturate at MAX_STEPS; no wrap. cur_init wraps only via DONE.
- start during busy is ignored with no side effect.

Test Plan:
- Reset: assert rst 2 cycles at any state → busy=0, res_valid=0, reset_nos=0, start_s0=start_s1=0, init_state=0.
- Identity network (f(x)=x), NODES=2: start → four results, res_init 0,1,2,3, each res_meet=2, res_period=1, res_timeout=0; done pulses once after the 4th accept.
- Toggle network (f(x)=~x), NODES=2 → every result res_meet=4, res_period=2; start_s0 low throughout PERIOD.
- 4-bit counter network (period 16), MAX_STEPS=8 → res_timeout=1, res_meet=8, res_period=0; exactly 8 start_s1 pulses between LOAD and REPORT.
- Backpressure: hold res_ready=0 for 10 cycles in REPORT → res_valid and all res_* stable, no start_s*/reset_nos pulses; release → next LOAD on the cycle after accept.
- rst asserted mid-RUN, then start again → sweep restarts at res_init=0 with correct results; a start pulse during busy is ignored (result count unchanged).

Source files
------------

// File: rtl/grn_attractor_ctrl.sv
// Sweeps every initial state of a two-copy GRN node array. For each state it
// finds the tortoise/hare meet point, measures the attractor period, and
// reports one result per state over a valid/ready handshake.
module grn_attractor_ctrl #(
  parameter int NODES     = 4,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              reset_nos,
  output logic              start_s0,
  output logic              start_s1,
  output logic [NODES-1:0]  init_state,
  input  logic [NODES-1:0]  s0_vec,
  input  logic [NODES-1:0]  s1_vec,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NODES-1:0]  res_init,
  output logic [STEP_W-1:0] res_meet,
  output logic [STEP_W-1:0] res_period,
  output logic              res_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PERIOD,
    REPORT,
    DONE
  } state_e;

  localparam logic [STEP_W-1:0] MaxCnt  = STEP_W'(MAX_STEPS);
  localparam logic [NODES-1:0]  LastIni = '1;

  state_e             state_q, state_d;
  logic [NODES-1:0]   cur_init_q, cur_init_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [STEP_W-1:0]  per_q, per_d;
  logic [STEP_W-1:0]  meet_q, meet_d;
  logic [STEP_W-1:0]  period_q, period_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, done_q, reset_nos_q, res_valid_q;
  logic [NODES-1:0]   init_state_q;

  logic vec_eq, run_match, run_limit, per_match, per_limit, accept;

  // Before two steps the copies trivially agree, so the compare is masked.
  assign vec_eq    = (s0_vec == s1_vec);
  assign run_match = (step_q >= STEP_W'(2)) && vec_eq;
  assign run_limit = (step_q == MaxCnt);
  assign per_match = (per_q != '0) && vec_eq;
  assign per_limit = (per_q == MaxCnt);
  assign accept    = res_valid_q && res_ready;

  always_comb begin
    state_d    = state_q;
    cur_init_d = cur_init_q;
    step_d     = step_q;
    per_d      = per_q;
    meet_d     = meet_q;
    period_d   = period_q;
    timeout_d  = timeout_q;
    start_s0   = 1'b0;
    start_s1   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_init_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        step_d    = '0;
        per_d     = '0;
        meet_d    = '0;
        period_d  = '0;
        timeout_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        if (run_match) begin
          meet_d  = step_q;
          state_d = PERIOD;
        end else if (run_limit) begin
          meet_d    = MaxCnt;
          period_d  = '0;
          timeout_d = 1'b1;
          state_d   = REPORT;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
          step_d   = step_q + STEP_W'(1);
        end
      end
      PERIOD: begin
        // Tortoise stays frozen; only the hare walks around the cycle.
        if (per_match) begin
          period_d = per_q;
          state_d  = REPORT;
        end else if (per_limit) begin
          period_d  = '0;
          timeout_d = 1'b1;
          state_d   = REPORT;
        end else begin
          start_s1 = 1'b1;
          per_d    = per_q + STEP_W'(1);
        end
      end
      REPORT: begin
        if (accept) begin
          if (cur_init_q == LastIni) begin
            state_d = DONE;
          end else begin
            cur_init_d = cur_init_q + NODES'(1);
            state_d    = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      start_s0 = 1'b0;
      start_s1 = 1'b0;
    end
  end

  // Handshake and node-control outputs are registered from the next state so
  // they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_init_q   <= '0;
      step_q       <= '0;
      per_q        <= '0;
      meet_q       <= '0;
      period_q     <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      reset_nos_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      init_state_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_init_q  <= cur_init_d;
      step_q      <= step_d;
      per_q       <= per_d;
      meet_q      <= meet_d;
      period_q    <= period_d;
      timeout_q   <= timeout_d;
      busy_q      <= state_d inside {LOAD, RUN, PERIOD, REPORT};
      done_q      <= (state_d == DONE);
      reset_nos_q <= (state_d == LOAD);
      res_valid_q <= (state_d == REPORT);
      if (state_d == LOAD) begin
        init_state_q <= cur_init_d;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign reset_nos   = reset_nos_q;
  assign init_state  = init_state_q;
  assign res_valid   = res_valid_q;
  assign res_init    = cur_init_q;
  assign res_meet    = meet_q;
  assign res_period  = period_q;
  assign res_timeout = timeout_q;

endmodule
